// File: rtl/lsu_bus_bridge.sv
// Bridges the core's combinational data-access port onto a registered valid/ready bus.
// Optional watchdog: define BRIDGE_TIMEOUT_EN to abort requests after TIMEOUT_CYCLES.
module lsu_bus_bridge #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              acs_en,
   input  logic              acs_wr,
   input  logic [XLEN/8-1:0] acs_bytes,
   input  logic [XLEN-1:0]   acs_addr,
   input  logic [XLEN-1:0]   acs_wdata,
   output logic [XLEN-1:0]   acs_rdata,
   output logic              stall,
   output logic              err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_req_wr,
   output logic [XLEN-1:0]   bus_req_addr,
   output logic [XLEN/8-1:0] bus_req_strb,
   output logic [XLEN-1:0]   bus_req_wdata,
   input  logic              bus_rsp_valid,
   input  logic [XLEN-1:0]   bus_rsp_data,
   input  logic              bus_rsp_err,
   output logic [1:0]        dbg_state
);
   localparam int LANES = XLEN / 8;
   localparam int OFFW  = $clog2(LANES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             wr_q, wr_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [OFFW-1:0]  off_q, off_d;
   logic [LANES-1:0] strb_q, strb_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [OFFW-1:0]    off;
   logic [2*LANES-1:0] strb_full;
   logic               misaligned;
   logic [XLEN-1:0]    rsp_shifted;
   logic               timeout;

   assign off         = acs_addr[OFFW-1:0];
   // Shift at double width so lanes pushed past the top are visible as a misalignment.
   assign strb_full   = {{LANES{1'b0}}, acs_bytes} << off;
   assign misaligned  = |strb_full[2*LANES-1:LANES];
   assign rsp_shifted = bus_rsp_data >> {off_q, 3'b000};

`ifdef BRIDGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE) cnt_d = '0;
      else if (state_q == S_REQ || state_q == S_WAIT) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   // No watchdog: this constant is always false.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      off_d   = off_q;
      strb_d  = strb_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (acs_en) begin
               if (misaligned) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = S_REQ;
                  wr_d    = acs_wr;
                  addr_d  = {acs_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                  off_d   = off;
                  strb_d  = strb_full[LANES-1:0];
                  wdata_d = acs_wdata << {off, 3'b000};
                  err_d   = 1'b0;
                  rdata_d = '0;
               end
            end
         end
         S_REQ: begin
            if (bus_req_ready) begin
               state_d = S_WAIT;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         S_WAIT: begin
            if (bus_rsp_valid) begin
               state_d = S_DONE;
               err_d   = bus_rsp_err;
               rdata_d = (bus_rsp_err || wr_q) ? '0 : rsp_shifted;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         off_q   <= '0;
         strb_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Bus handshake: a request transfers on a cycle where bus_req_valid and bus_req_ready are both 1;
   // fields stay stable while valid waits for ready; a response is taken only in WAIT.
   assign bus_req_valid = (state_q == S_REQ);
   assign bus_req_wr    = wr_q;
   assign bus_req_addr  = addr_q;
   assign bus_req_strb  = strb_q;
   assign bus_req_wdata = wdata_q;

   assign acs_rdata = (state_q == S_DONE) ? rdata_q : '0;
   assign err       = (state_q == S_DONE) & err_q;
   assign stall     = acs_en & (state_q != S_DONE);
   assign dbg_state = state_q;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboard bench for lsu_bus_bridge: directed accesses, a scripted bus responder and monitors.
module tb_lsu_bus_bridge;
   logic        clk;
   logic        rstn;
   logic        acs_en;
   logic        acs_wr;
   logic [7:0]  acs_bytes;
   logic [63:0] acs_addr;
   logic [63:0] acs_wdata;
   logic [63:0] acs_rdata;
   logic        stall;
   logic        err;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_wr;
   logic [63:0] bus_req_addr;
   logic [7:0]  bus_req_strb;
   logic [63:0] bus_req_wdata;
   logic        bus_rsp_valid;
   logic [63:0] bus_rsp_data;
   logic        bus_rsp_err;
   logic [1:0]  dbg_state;

   typedef struct packed {
      logic        wr;
      logic [63:0] addr;
      logic [7:0]  strb;
      logic [63:0] wdata;
   } req_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } comp_t;

   req_t  req_q[$];
   comp_t comp_q[$];

   int tests = 0;
   int fails = 0;

   int          cfg_rdy_dly     = 0;
   logic [63:0] cfg_rsp_data    = '0;
   logic        cfg_rsp_err     = 1'b0;
   logic        cfg_rsp_hold    = 1'b0;
   logic        cfg_never_ready = 1'b0;
   logic        cfg_stray       = 1'b0;

   lsu_bus_bridge #(.XLEN(64), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rstn(rstn),
      .acs_en(acs_en), .acs_wr(acs_wr), .acs_bytes(acs_bytes), .acs_addr(acs_addr),
      .acs_wdata(acs_wdata), .acs_rdata(acs_rdata), .stall(stall), .err(err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wr(bus_req_wr),
      .bus_req_addr(bus_req_addr), .bus_req_strb(bus_req_strb), .bus_req_wdata(bus_req_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // bus responder
   initial begin
      int wait_cnt;
      int rsp_cnt;
      wait_cnt = 0;
      rsp_cnt  = 0;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      bus_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus_req_ready = 1'b0;
         bus_rsp_valid = 1'b0;
         bus_rsp_err   = 1'b0;
         if (cfg_stray) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            cfg_stray     = 1'b0;
         end else if (!rstn) begin
            wait_cnt = 0;
            rsp_cnt  = 0;
         end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && !cfg_rsp_hold) begin
               bus_rsp_valid = 1'b1;
               bus_rsp_data  = cfg_rsp_data;
               bus_rsp_err   = cfg_rsp_err;
            end
         end else if (bus_req_valid && !cfg_never_ready) begin
            if (wait_cnt >= cfg_rdy_dly) begin
               bus_req_ready = 1'b1;
               wait_cnt      = 0;
               rsp_cnt       = 1;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // request monitor: fields must match the expected request every cycle valid is high
   always @(negedge clk) begin
      if (rstn && bus_req_valid) begin
         if (req_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got addr 0x%0h expected no request", bus_req_addr);
         end else begin
            check("req_wr", {63'd0, bus_req_wr}, {63'd0, req_q[0].wr});
            check("req_addr", bus_req_addr, req_q[0].addr);
            check("req_strb", {56'd0, bus_req_strb}, {56'd0, req_q[0].strb});
            check("req_wdata", bus_req_wdata, req_q[0].wdata);
            if (bus_req_ready) void'(req_q.pop_front());
         end
      end
   end

   // completion monitor
   always @(negedge clk) begin
      if (rstn && acs_en && !stall) begin
         if (comp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got rdata 0x%0h expected no completion", acs_rdata);
         end else begin
            check("done_rdata", acs_rdata, comp_q[0].rdata);
            check("done_err", {63'd0, err}, {63'd0, comp_q[0].err});
            void'(comp_q.pop_front());
         end
      end else if (rstn && err) begin
         tests++;
         fails++;
         $display("FAIL spurious_err: got 1 expected 0");
      end
   end

   // driver
   task automatic access(input string name, input logic wr, input logic [7:0] bytes,
                         input logic [63:0] addr, input logic [63:0] wdata, input int rdy_dly,
                         input logic [63:0] rsp_data, input logic rsp_err, input logic mis,
                         input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input int exp_stall);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      if (!mis) req_q.push_back('{wr: wr, addr: exp_addr, strb: exp_strb, wdata: exp_wdata});
      comp_q.push_back('{rdata: exp_rdata, err: exp_err});
      @(posedge clk);
      #1;
      cfg_rdy_dly  = rdy_dly;
      cfg_rsp_data = rsp_data;
      cfg_rsp_err  = rsp_err;
      acs_en    = 1'b1;
      acs_wr    = wr;
      acs_bytes = bytes;
      acs_addr  = addr;
      acs_wdata = wdata;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         n++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_hang: got stall still high expected completion", name);
      end
      check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
      @(posedge clk);
      #1;
      acs_en    = 1'b0;
      acs_wr    = 1'b0;
      acs_bytes = '0;
      acs_addr  = '0;
      acs_wdata = '0;
   endtask

   initial begin
      bit seen;
      rstn      = 1'b0;
      acs_en    = 1'b1;
      acs_wr    = 1'b0;
      acs_bytes = 8'h0F;
      acs_addr  = 64'h10;
      acs_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_stall_follows_en", {63'd0, stall}, 64'd1);
      check("rst_state", {62'd0, dbg_state}, 64'd0);
      check("rst_req_valid", {63'd0, bus_req_valid}, 64'd0);
      check("rst_req_addr", bus_req_addr, 64'd0);
      check("rst_rdata", acs_rdata, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      @(posedge clk);
      #1;
      acs_en = 1'b0;
      rstn   = 1'b1;
      @(negedge clk);
      check("idle_stall", {63'd0, stall}, 64'd0);

      access("ld_word", 1'b0, 8'h0F, 64'h1004, 64'h0, 0, 64'hAABBCCDD_11223344, 1'b0, 1'b0,
             64'h1000, 8'hF0, 64'h0, 64'h00000000_AABBCCDD, 1'b0, 3);
      access("st_byte", 1'b1, 8'h01, 64'h2003, 64'h5A, 4, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0,
             64'h2000, 8'h08, 64'h5A00_0000, 64'h0, 1'b0, 7);
      access("mis_word", 1'b0, 8'h0F, 64'h3006, 64'h0, 0, 64'h0, 1'b0, 1'b1,
             64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1);
      access("bus_err", 1'b0, 8'hFF, 64'h4000, 64'h0, 0, 64'h1234, 1'b1, 1'b0,
             64'h4000, 8'hFF, 64'h0, 64'h0, 1'b1, 3);
      access("ld_half", 1'b0, 8'h03, 64'h5006, 64'h0, 0, 64'h8899_7766_5544_3322, 1'b0, 1'b0,
             64'h5000, 8'hC0, 64'h0, 64'h8899, 1'b0, 3);
      access("st_dword", 1'b1, 8'hFF, 64'h6000, 64'h0123_4567_89AB_CDEF, 1, 64'h0, 1'b0, 1'b0,
             64'h6000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 4);
      access("mis_half_top", 1'b0, 8'h03, 64'h7007, 64'h0, 0, 64'h0, 1'b0, 1'b1,
             64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1);
      access("ld_byte_top", 1'b0, 8'h01, 64'h7007, 64'h0, 0, 64'hAB11_2233_4455_6677, 1'b0, 1'b0,
             64'h7000, 8'h80, 64'h0, 64'hAB, 1'b0, 3);
      access("st_half", 1'b1, 8'h03, 64'h7102, 64'hBEEF, 0, 64'h0, 1'b0, 1'b0,
             64'h7100, 8'h0C, 64'hBEEF_0000, 64'h0, 1'b0, 3);

      // reset while waiting for the response
      cfg_rsp_hold = 1'b1;
      cfg_rdy_dly  = 0;
      req_q.push_back('{wr: 1'b0, addr: 64'h8000, strb: 8'hFF, wdata: 64'h0});
      @(posedge clk);
      #1;
      acs_en    = 1'b1;
      acs_wr    = 1'b0;
      acs_bytes = 8'hFF;
      acs_addr  = 64'h8000;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dbg_state == 2'd2) begin
            seen = 1'b1;
            break;
         end
      end
      check("rw_reached_wait", {63'd0, seen}, 64'd1);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(negedge clk);
      check("rw_state", {62'd0, dbg_state}, 64'd0);
      check("rw_req_valid", {63'd0, bus_req_valid}, 64'd0);
      check("rw_req_strb", {56'd0, bus_req_strb}, 64'd0);
      check("rw_req_addr", bus_req_addr, 64'd0);
      check("rw_stall", {63'd0, stall}, 64'd1);
      @(posedge clk);
      #1;
      acs_en       = 1'b0;
      rstn         = 1'b1;
      cfg_rsp_hold = 1'b0;
      @(negedge clk);
      cfg_stray = 1'b1;
      @(negedge clk);
      check("stray_state", {62'd0, dbg_state}, 64'd0);
      check("stray_rdata", acs_rdata, 64'd0);
      @(negedge clk);
      check("stray_after_state", {62'd0, dbg_state}, 64'd0);
      check("stray_after_valid", {63'd0, bus_req_valid}, 64'd0);
      access("ld_after_rst", 1'b0, 8'h0F, 64'h9000, 64'h0, 0, 64'h1111_2222_CAFE_F00D, 1'b0, 1'b0,
             64'h9000, 8'h0F, 64'h0, 64'h1111_2222_CAFE_F00D, 1'b0, 3);

`ifdef BRIDGE_TIMEOUT_EN
      cfg_never_ready = 1'b1;
      access("timeout", 1'b0, 8'hFF, 64'hA000, 64'h0, 0, 64'h0, 1'b0, 1'b0,
             64'hA000, 8'hFF, 64'h0, 64'h0, 1'b1, 9);
      @(negedge clk);
      check("timeout_valid_drop", {63'd0, bus_req_valid}, 64'd0);
      if (req_q.size() > 0) void'(req_q.pop_front());
      cfg_never_ready = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check("comp_q_drained", 64'(comp_q.size()), 64'd0);
      check("req_q_drained", 64'(req_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "global timeout");
   end
endmodule
